nr_divsqrt_seq: RTL and testbench

- Parametrised, sequential successor to the combinational controlled add/subtract cellular array.
- A single row of WIDTH+2 add/subtract cells is reused once per cycle.
- Performs non-restoring unsigned division or non-restoring square root; the operation is selected by mode.
- Sits behind the TT top-level pin wrapper; one operation in flight at a time.

---
 rtl/nr_divsqrt_seq.sv | 147 ++++++++++++++
 tb/tb_nr_divsqrt_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nr_divsqrt_seq.sv
// Sequential non-restoring divider / square-root: one add/subtract row reused per cycle.
// Optional NR_DIVSQRT_SIGNED_EN makes divide two's complement (magnitudes in, signs applied in FIX).
module nr_divsqrt_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int PW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pr;
  logic [WIDTH-1:0] num, den, qacc;
  logic             md;
  logic             accept;
`ifdef NR_DIVSQRT_SIGNED_EN
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] a_org;
`endif

  logic [PW-1:0]    pr_sh, step_term, pr_step, fix_term, pr_fix;
  logic [WIDTH-1:0] q_res, r_res;
  logic             dz_res;
  logic             unused_pr_top;

  // DONE counts as an idle edge so a held start restarts without a gap.
  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: if (start) state_nx = ITER;
      // The extra ITER cycle at cnt==0 fixes latency at N+2 for every operand.
      ITER: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = start ? ITER : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared add/subtract row; the sign of pr picks add vs subtract.
  always_comb begin
    if (md) begin
      pr_sh     = {pr[PW-3:0], num[WIDTH-1:WIDTH-2]};
      step_term = {qacc, pr[PW-1], 1'b1};
      fix_term  = {1'b0, qacc, 1'b1};
    end else begin
      pr_sh     = {pr[PW-2:0], num[WIDTH-1]};
      step_term = {2'b00, den};
      fix_term  = {2'b00, den};
    end
    pr_step = pr[PW-1] ? pr_sh + step_term : pr_sh - step_term;
    pr_fix  = pr[PW-1] ? pr + fix_term : pr;
  end

  assign unused_pr_top = ^pr_fix[PW-1:WIDTH];

  always_comb begin
    dz_res = !md && (den == '0);
`ifdef NR_DIVSQRT_SIGNED_EN
    q_res = dz_res ? '1    : (neg_q ? -qacc : qacc);
    r_res = dz_res ? a_org : (neg_r ? -pr_fix[WIDTH-1:0] : pr_fix[WIDTH-1:0]);
`else
    q_res = dz_res ? '1 : qacc;
    r_res = pr_fix[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pr   <= '0;
      num  <= '0;
      den  <= '0;
      qacc <= '0;
      md   <= 1'b0;
      q    <= '0;
      r    <= '0;
      dz   <= 1'b0;
`ifdef NR_DIVSQRT_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      a_org <= '0;
`endif
    end else if (accept) begin
      md   <= mode;
      pr   <= '0;
      qacc <= '0;
      dz   <= 1'b0;
      cnt  <= mode ? CW'(WIDTH / 2) : CW'(WIDTH);
`ifdef NR_DIVSQRT_SIGNED_EN
      a_org <= a;
      if (!mode) begin
        num   <= a[WIDTH-1] ? -a : a;
        den   <= b[WIDTH-1] ? -b : b;
        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_r <= a[WIDTH-1];
      end else begin
        num   <= a;
        den   <= b;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
`else
      num <= a;
      den <= b;
`endif
    end else begin
      case (state)
        ITER: if (cnt != '0) begin
          pr   <= pr_step;
          qacc <= {qacc[WIDTH-2:0], ~pr_step[PW-1]};
          num  <= md ? (num << 2) : (num << 1);
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          q  <= q_res;
          r  <= r_res;
          dz <= dz_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_divsqrt_seq.sv
// Directed self-checking bench for nr_divsqrt_seq at WIDTH=8.
module tb_nr_divsqrt_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       busy, done, dz;
  logic [7:0] q, r;

  int errors = 0;
  int checks = 0;

  nr_divsqrt_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  // Stimulus only: issues one op and reports what it saw; lat = -1 on timeout.
  task automatic do_op(input logic md, input logic [7:0] aa, input logic [7:0] bb,
                       output logic [7:0] qq, output logic [7:0] rr, output logic ddz,
                       output int lat, output logic busy1, output logic dz1);
    @(negedge clk);
    mode = md; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    dz1 = dz;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!done && lat < 40);
    if (!done) lat = -1;
    qq = q; rr = r; ddz = dz;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (q !== 8'd0) begin errors++; $display("FAIL reset_q got %0d want 0", q); end
    checks++; if (r !== 8'd0) begin errors++; $display("FAIL reset_r got %0d want 0", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", dz); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divide;
    logic [7:0] qq, rr; logic ddz, b1, d1; int lat;
    do_op(1'b0, 8'd100, 8'd7, qq, rr, ddz, lat, b1, d1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL div_busy got %b want 1", b1); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL div_latency got %0d want 10", lat); end
    checks++; if (qq !== 8'd14) begin errors++; $display("FAIL div_q got %0d want 14", qq); end
    checks++; if (rr !== 8'd2) begin errors++; $display("FAIL div_r got %0d want 2", rr); end
    checks++; if (ddz !== 1'b0) begin errors++; $display("FAIL div_dz got %b want 0", ddz); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_busy_after got %b want 0", busy); end
  endtask

  task automatic test_sqrt;
    logic [7:0] qq, rr; logic ddz, b1, d1; int lat;
    do_op(1'b1, 8'd200, 8'd99, qq, rr, ddz, lat, b1, d1);
    checks++; if (lat !== 6) begin errors++; $display("FAIL sqrt_latency got %0d want 6", lat); end
    checks++; if (qq !== 8'd14) begin errors++; $display("FAIL sqrt200_q got %0d want 14", qq); end
    checks++; if (rr !== 8'd4) begin errors++; $display("FAIL sqrt200_r got %0d want 4", rr); end
    checks++; if (ddz !== 1'b0) begin errors++; $display("FAIL sqrt200_dz got %b want 0", ddz); end
    do_op(1'b1, 8'd255, 8'd0, qq, rr, ddz, lat, b1, d1);
    checks++; if (qq !== 8'd15) begin errors++; $display("FAIL sqrt255_q got %0d want 15", qq); end
    checks++; if (rr !== 8'd30) begin errors++; $display("FAIL sqrt255_r got %0d want 30", rr); end
    do_op(1'b1, 8'd0, 8'd3, qq, rr, ddz, lat, b1, d1);
    checks++; if (qq !== 8'd0) begin errors++; $display("FAIL sqrt0_q got %0d want 0", qq); end
    checks++; if (rr !== 8'd0) begin errors++; $display("FAIL sqrt0_r got %0d want 0", rr); end
  endtask

  task automatic test_div_zero;
    logic [7:0] qq, rr; logic ddz, b1, d1; int lat;
    do_op(1'b0, 8'd55, 8'd0, qq, rr, ddz, lat, b1, d1);
    checks++; if (lat !== 10) begin errors++; $display("FAIL dz_latency got %0d want 10", lat); end
    checks++; if (qq !== 8'd255) begin errors++; $display("FAIL dz_q got %0d want 255", qq); end
    checks++; if (rr !== 8'd55) begin errors++; $display("FAIL dz_r got %0d want 55", rr); end
    checks++; if (ddz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", ddz); end
    do_op(1'b0, 8'd255, 8'd1, qq, rr, ddz, lat, b1, d1);
    checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL dz_clear_at_accept got %b want 0", d1); end
    checks++; if (qq !== 8'd255) begin errors++; $display("FAIL div1_q got %0d want 255", qq); end
    checks++; if (rr !== 8'd0) begin errors++; $display("FAIL div1_r got %0d want 0", rr); end
    checks++; if (ddz !== 1'b0) begin errors++; $display("FAIL div1_dz got %b want 0", ddz); end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    mode = 1'b0; a = 8'd100; b = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); lat++; @(negedge clk); end
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(posedge clk); lat++; @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL ignore_latency got %0d want 10", lat); end
    checks++; if (q !== 8'd14) begin errors++; $display("FAIL ignore_q got %0d want 14", q); end
    checks++; if (r !== 8'd2) begin errors++; $display("FAIL ignore_r got %0d want 2", r); end
  endtask

  task automatic test_back_to_back;
    int gap;
    @(negedge clk);
    mode = 1'b0; a = 8'd200; b = 8'd7; start = 1'b1;
    gap = 0;
    do begin @(posedge clk); gap++; @(negedge clk); end while (!done && gap < 40);
    checks++; if (q !== 8'd28 || r !== 8'd4) begin errors++; $display("FAIL b2b_first got q=%0d r=%0d want q=28 r=4", q, r); end
    a = 8'd50; b = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_held got %b want 1", busy); end
    gap = 1;
    while (!done && gap < 40) begin @(posedge clk); gap++; @(negedge clk); end
    checks++; if (gap !== 11) begin errors++; $display("FAIL b2b_interval got %0d want 11", gap); end
    checks++; if (q !== 8'd10 || r !== 8'd0) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d want q=10 r=0", q, r); end
  endtask

  task automatic test_mid_reset;
    logic [7:0] qq, rr; logic ddz, b1, d1; int lat; logic seen;
    @(negedge clk);
    mode = 1'b0; a = 8'd100; b = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, q, r, dz} !== 19'd0) begin errors++;
      $display("FAIL midreset_outputs got busy=%b done=%b q=%0d r=%0d dz=%b want all 0", busy, done, q, r, dz); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done got %b want 0", seen); end
    do_op(1'b0, 8'd9, 8'd3, qq, rr, ddz, lat, b1, d1);
    checks++; if (qq !== 8'd3 || rr !== 8'd0) begin errors++; $display("FAIL midreset_next got q=%0d r=%0d want q=3 r=0", qq, rr); end
  endtask

`ifdef NR_DIVSQRT_SIGNED_EN
  task automatic test_signed;
    logic [7:0] qq, rr; logic ddz, b1, d1; int lat;
    do_op(1'b0, 8'h9C, 8'd7, qq, rr, ddz, lat, b1, d1);
    checks++; if (qq !== 8'hF2 || rr !== 8'hFE) begin errors++; $display("FAIL signed_div got q=%h r=%h want q=f2 r=fe", qq, rr); end
    do_op(1'b0, 8'h80, 8'hFF, qq, rr, ddz, lat, b1, d1);
    checks++; if (qq !== 8'h80 || rr !== 8'h00 || ddz !== 1'b0) begin errors++; $display("FAIL signed_ovf got q=%h r=%h dz=%b want q=80 r=00 dz=0", qq, rr, ddz); end
    do_op(1'b0, 8'hF0, 8'h00, qq, rr, ddz, lat, b1, d1);
    checks++; if (qq !== 8'hFF || rr !== 8'hF0 || ddz !== 1'b1) begin errors++; $display("FAIL signed_dz got q=%h r=%h dz=%b want q=ff r=f0 dz=1", qq, rr, ddz); end
  endtask
`endif

  initial begin
    test_reset;
    test_divide;
    test_sqrt;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    test_mid_reset;
`ifdef NR_DIVSQRT_SIGNED_EN
    test_signed;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
